irq_ctl: RTL

- Interrupt controller placed between the peripheral interrupt sources (tmr, ser, sdc, kbd, lcd, future devices) and the 16-bit CPU interrupt request input.
- Synchronizes, latches, masks and prioritizes up to 16 request lines. Drives the CPU irq vector with pending-and-enabled requests.
- Bus slave in extended I/O space at 0xFFFF90: 4 words, decoded by the top level as x_i_o_stb with addr[5:4] == 2'b01.

---
 rtl/irq_ctl.sv | 74 +++++++
 1 files changed

// File: rtl/irq_ctl.sv
// irq_ctl: synchronizes, latches, masks and prioritizes 16 interrupt sources for the CPU
module irq_ctl #(
  parameter bit SYNC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic [15:0] src,
  output logic [15:0] irq
);
  logic [15:0] s, s_prev, pending, mask, mode, act, rise, pend_clr, stat_set, pend_nx;
  logic [3:0]  idx;
  logic [31:0] rdata;
  logic        wr;
  logic        unused_hi;
  assign unused_hi = ^data_in[31:16];
  if (SYNC) begin : g_sync
    logic [15:0] sync1, sync2;
    // two-flop synchronizer on every request line
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= '0;
        sync2 <= '0;
      end else begin
        sync1 <= src;
        sync2 <= sync1;
      end
    end
    assign s = sync2;
  end else begin : g_nosync
    assign s = src;
  end
  assign wr       = stb & we;
  assign rise     = s & ~s_prev;
  assign pend_clr = (wr && addr == 2'd0) ? data_in[15:0] & mode : '0;
  assign stat_set = (wr && addr == 2'd3) ? data_in[15:0] & mode : '0;
  // edge bits: set (edge or software) beats clear, else hold; level bits follow s
  assign pend_nx  = (mode & ((pending & ~pend_clr) | rise | stat_set)) | (~mode & s);
  assign act      = pending & mask;
  assign irq      = act;
  assign ack      = stb;
  // highest-numbered active request wins
  always_comb begin
    idx = '0;
    for (int i = 0; i < 16; i++) idx = act[i] ? 4'(i) : idx;
  end
  // read mux, driven only while a read is selected
  always_comb begin
    rdata = addr == 2'd0 ? {16'h0, pending} :
            addr == 2'd1 ? {16'h0, mask} :
            addr == 2'd2 ? {16'h0, mode} :
                           {|act, 27'h0, idx};
    data_out = (stb & ~we) ? rdata : '0;
  end
  // pending/edge history update and bus register writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev  <= '0;
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      s_prev  <= s;
      pending <= pend_nx;
      if (wr && addr == 2'd1) mask <= data_in[15:0];
      if (wr && addr == 2'd2) mode <= data_in[15:0];
    end
  end
endmodule
